// File: rtl/ssds_scan_bus_interface.sv
// Multiplexed seven-segment scan driver with a strobed 32-bit register window.
// Register reads are combinational; segment, dot and digit-select outputs are registered.
module ssds_scan_bus_interface #(
    parameter int          DIGITS    = 4,
    parameter int          SCAN_DIV  = 50000,
    parameter int          BLINK_DIV = 128,
    parameter logic [31:0] BASE_ADDR = 32'h0
) (
    input  logic              clk,
    input  logic              rst,
    output logic [6:0]        seg,
    output logic              dot,
    output logic [DIGITS-1:0] an,
    input  logic [31:0]       addr_bus,
    inout  logic [31:0]       data_bus,
    input  logic              rd_bus,
    input  logic              wr_bus,
    input  logic [3:0]        data_mask_bus,
    output logic              fc_bus
);
    localparam int              SW         = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int              FW         = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [SW-1:0]   SCAN_LAST  = SW'(SCAN_DIV - 1);
    localparam logic [FW-1:0]   FRAME_LAST = FW'(BLINK_DIV - 1);
    localparam logic [2:0]      IDX_LAST   = 3'(DIGITS - 1);
    localparam logic [29:0]     BASE_WORD  = BASE_ADDR[31:2];

    logic [7:0]        ctrl_r;
    logic [7:0]        dots_r;
    logic [7:0]        blink_mask_r;
    logic [7:0]        dig_r [8];
    logic              written_r;
    logic [SW-1:0]     scan_cnt_r;
    logic [FW-1:0]     frame_cnt_r;
    logic [2:0]        idx_r;
    logic              phase_r;
    logic [6:0]        seg_r;
    logic              dot_r;
    logic [DIGITS-1:0] an_r;

    logic [29:0]       word_off_s;
    logic              in_win_s;
    logic              rd_hit_s;
    logic              wr_hit_s;
    logic [31:0]       reg_word_s;
    logic [31:0]       rd_data_s;
    logic [3:0]        byte_we_s;
    logic [7:0]        byte_data_s [4];
    logic              blank_s;

    function automatic logic [6:0] decode_digit(input logic [7:0] code);
        logic [6:0] hex;
        case (code[3:0])
            4'h0:    hex = 7'h3F;
            4'h1:    hex = 7'h06;
            4'h2:    hex = 7'h5B;
            4'h3:    hex = 7'h4F;
            4'h4:    hex = 7'h66;
            4'h5:    hex = 7'h6D;
            4'h6:    hex = 7'h7D;
            4'h7:    hex = 7'h07;
            4'h8:    hex = 7'h7F;
            4'h9:    hex = 7'h6F;
            4'hA:    hex = 7'h77;
            4'hB:    hex = 7'h7C;
            4'hC:    hex = 7'h39;
            4'hD:    hex = 7'h5E;
            4'hE:    hex = 7'h79;
            default: hex = 7'h71;
        endcase
        return code[7] ? hex : code[6:0];
    endfunction

    assign word_off_s = addr_bus[31:2] - BASE_WORD;
    assign in_win_s   = (addr_bus[31:2] >= BASE_WORD) && (word_off_s < 30'd6);
    assign rd_hit_s   = in_win_s && rd_bus && !wr_bus;
    assign wr_hit_s   = in_win_s && wr_bus && !rd_bus;

    // Register word selected by the address, before lane alignment.
    always_comb begin
        reg_word_s = 32'h0;
        case (word_off_s[2:0])
            3'd0:    reg_word_s = {24'h0, ctrl_r};
            3'd1:    reg_word_s = {dig_r[3], dig_r[2], dig_r[1], dig_r[0]};
            3'd2:    reg_word_s = {dig_r[7], dig_r[6], dig_r[5], dig_r[4]};
            3'd3:    reg_word_s = {24'h0, dots_r};
            3'd4:    reg_word_s = {24'h0, blink_mask_r};
            3'd5:    reg_word_s = {28'h0, phase_r, idx_r};
            default: reg_word_s = 32'h0;
        endcase
    end

    assign rd_data_s = reg_word_s >> {addr_bus[1:0], 3'b000};
    assign data_bus  = rd_hit_s ? rd_data_s : 32'hzzzz_zzzz;
    assign fc_bus    = rd_hit_s ? 1'b1 : (wr_hit_s ? written_r : 1'bz);

    // Register byte b is fed from bus lane (b - addr[1:0]); bytes below the offset are untouched.
    always_comb begin
        byte_we_s = 4'b0;
        for (int b = 0; b < 4; b++) begin
            byte_data_s[b] = data_bus[{(2'(b) - addr_bus[1:0]), 3'b000} +: 8];
            byte_we_s[b]   = (2'(b) >= addr_bus[1:0]) ? data_mask_bus[2'(b) - addr_bus[1:0]] : 1'b0;
        end
    end

    // Register file: one capture per write strobe; the written flag drives fc high afterwards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_r       <= 8'h0;
            dots_r       <= 8'h0;
            blink_mask_r <= 8'h0;
            written_r    <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                dig_r[i] <= 8'h0;
            end
        end else begin
            written_r <= wr_hit_s;
            if (wr_hit_s && !written_r) begin
                case (word_off_s[2:0])
                    3'd0: if (byte_we_s[0]) ctrl_r <= byte_data_s[0];
                    3'd1: begin
                        for (int b = 0; b < 4; b++) begin
                            if (byte_we_s[b] && (b < DIGITS)) dig_r[b] <= byte_data_s[b];
                        end
                    end
                    3'd2: begin
                        for (int b = 0; b < 4; b++) begin
                            if (byte_we_s[b] && (b + 4 < DIGITS)) dig_r[b + 4] <= byte_data_s[b];
                        end
                    end
                    3'd3: if (byte_we_s[0]) dots_r <= byte_data_s[0];
                    3'd4: if (byte_we_s[0]) blink_mask_r <= byte_data_s[0];
                    default: ;
                endcase
            end
        end
    end

    // Slot, digit-index, frame and blink-phase counters; all parked at zero while disabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_cnt_r  <= '0;
            frame_cnt_r <= '0;
            idx_r       <= 3'd0;
            phase_r     <= 1'b0;
        end else if (!ctrl_r[0]) begin
            scan_cnt_r  <= '0;
            frame_cnt_r <= '0;
            idx_r       <= 3'd0;
            phase_r     <= 1'b0;
        end else if (scan_cnt_r == SCAN_LAST) begin
            scan_cnt_r <= '0;
            if (idx_r == IDX_LAST) begin
                idx_r <= 3'd0;
                if (frame_cnt_r == FRAME_LAST) begin
                    frame_cnt_r <= '0;
                    phase_r     <= ~phase_r;
                end else begin
                    frame_cnt_r <= frame_cnt_r + 1'b1;
                end
            end else begin
                idx_r <= idx_r + 3'd1;
            end
        end else begin
            scan_cnt_r <= scan_cnt_r + 1'b1;
        end
    end

    assign blank_s = ctrl_r[1] && blink_mask_r[idx_r] && phase_r;

    // Display output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_r <= 7'h0;
            dot_r <= 1'b0;
            an_r  <= '0;
        end else if (!ctrl_r[0]) begin
            seg_r <= 7'h0;
            dot_r <= 1'b0;
            an_r  <= '0;
        end else begin
            an_r  <= DIGITS'(1'b1) << idx_r;
            seg_r <= blank_s ? 7'h0 : decode_digit(dig_r[idx_r]);
            dot_r <= blank_s ? 1'b0 : dots_r[idx_r];
        end
    end

    assign seg = seg_r;
    assign dot = dot_r;
    assign an  = an_r;
endmodule

// File: tb/tb_ssds_scan_bus_interface.sv
// Bench for ssds_scan_bus_interface: directed bus/scan scenarios plus randomized register traffic,
// checked against a register map and an elapsed-cycle display model.
module tb_ssds_scan_bus_interface;
    localparam int          D    = 4;
    localparam int          S    = 4;
    localparam int          B    = 1;
    localparam logic [31:0] BASE = 32'h0000_1000;
    localparam logic [6:0]  HEX [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                         7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  addr;
    logic         rd, wr;
    logic [3:0]   mask;
    logic         drv_en;
    logic [31:0]  drv_val;
    wire  [31:0]  data_bus;
    wire          fc_bus;
    logic [6:0]   seg;
    logic         dot;
    logic [D-1:0] an;

    int checks, errors;
    logic [7:0] m_ctrl, m_dots, m_bmask;
    logic [7:0] m_dig [8];
    int en_edges;

    assign data_bus = drv_en ? drv_val : 32'hzzzz_zzzz;
    always #5 clk = ~clk;

    ssds_scan_bus_interface #(.DIGITS(D), .SCAN_DIV(S), .BLINK_DIV(B), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst(rst), .seg(seg), .dot(dot), .an(an),
        .addr_bus(addr), .data_bus(data_bus), .rd_bus(rd), .wr_bus(wr),
        .data_mask_bus(mask), .fc_bus(fc_bus)
    );

    // Number of consecutive clock edges seen with the display enabled.
    always @(posedge clk or posedge rst) begin
        if (rst) en_edges <= 0;
        else if (m_ctrl[0]) en_edges <= en_edges + 1;
        else en_edges <= 0;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    function automatic logic [6:0] seg_of(input logic [7:0] c);
        return c[7] ? HEX[c[3:0]] : c[6:0];
    endfunction

    function automatic logic [31:0] model_word(input int off);
        int idx, ph;
        idx = (en_edges / S) % D;
        ph  = (en_edges / (S * D * B)) % 2;
        case (off)
            0: return {24'h0, m_ctrl};
            1: return {m_dig[3], m_dig[2], m_dig[1], m_dig[0]};
            2: return {m_dig[7], m_dig[6], m_dig[5], m_dig[4]};
            3: return {24'h0, m_dots};
            4: return {24'h0, m_bmask};
            5: return {28'h0, ph[0], idx[2:0]};
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        m_ctrl = 8'h0; m_dots = 8'h0; m_bmask = 8'h0;
        for (int i = 0; i < 8; i++) m_dig[i] = 8'h0;
    endtask

    task automatic model_write(input int off, input int lane, input logic [31:0] data, input logic [3:0] msk);
        for (int k = 0; k < 4; k++) begin
            int b;
            logic [7:0] v;
            b = lane + k;
            v = data[8*k +: 8];
            if (msk[k] && b < 4) begin
                case (off)
                    0: if (b == 0) m_ctrl = v;
                    1: if (b < D) m_dig[b] = v;
                    2: if (b + 4 < D) m_dig[b + 4] = v;
                    3: if (b == 0) m_dots = v;
                    4: if (b == 0) m_bmask = v;
                    default: ;
                endcase
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_released(input string tag);
        checks++;
        assert (((|data_bus) !== 1'b1) && (fc_bus !== 1'b1)) else begin
            errors++;
            $error("FAIL %s: observed data=%h fc=%b expected released bus", tag, data_bus, fc_bus);
        end
    endtask

    task automatic bus_read(input int off, input int lane, input string tag);
        @(posedge clk); #1;
        addr = BASE + 32'(off * 4 + lane);
        rd = 1'b1;
        #2;
        chk(tag, data_bus, model_word(off) >> (8 * lane));
        chk({tag, "_fc"}, {31'h0, fc_bus}, 32'h1);
        @(posedge clk); #1;
        rd = 1'b0;
        addr = 32'h0;
    endtask

    task automatic bus_write(input int off, input int lane, input logic [31:0] data,
                             input logic [3:0] msk, input string tag);
        @(posedge clk); #1;
        addr = BASE + 32'(off * 4 + lane);
        drv_val = data; drv_en = 1'b1; mask = msk; wr = 1'b1;
        #2;
        chk({tag, "_fc_capture"}, {31'h0, fc_bus}, 32'h0);
        @(posedge clk); #1;
        chk({tag, "_fc_done"}, {31'h0, fc_bus}, 32'h1);
        wr = 1'b0; drv_en = 1'b0; mask = 4'h0; addr = 32'h0;
        model_write(off, lane, data, msk);
    endtask

    task automatic check_display(input string tag);
        int n, k, idx, ph;
        logic blank;
        logic [6:0] es;
        logic ed;
        logic [D-1:0] ea;
        n = en_edges;
        es = 7'h0; ed = 1'b0; ea = '0;
        if (n != 0) begin
            k = n - 1;
            idx = (k / S) % D;
            ph = (k / (S * D * B)) % 2;
            blank = m_ctrl[1] && m_bmask[idx] && (ph == 1);
            ea = D'(1) << idx;
            es = blank ? 7'h0 : seg_of(m_dig[idx]);
            ed = blank ? 1'b0 : m_dots[idx];
        end
        chk({tag, "_an"}, 32'(an), 32'(ea));
        chk({tag, "_seg"}, 32'(seg), 32'(es));
        chk({tag, "_dot"}, 32'(dot), 32'(ed));
    endtask

    initial begin
        checks = 0; errors = 0;
        rst = 1'b1; rd = 1'b0; wr = 1'b0; addr = 32'h0; mask = 4'h0; drv_en = 1'b0; drv_val = 32'h0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_seg", 32'(seg), 32'h0);
        chk("rst_an", 32'(an), 32'h0);
        chk("rst_dot", 32'(dot), 32'h0);
        chk_released("rst_bus");
        @(negedge clk) rst = 1'b0;
        for (int off = 0; off < 6; off++) bus_read(off, 0, "rst_reg");

        // Basic scan with hex-coded digits.
        bus_write(0, 0, 32'h0000_0001, 4'h1, "ctrl_en");
        bus_write(1, 0, 32'h8F86_0000, 4'hF, "dig_lo");
        bus_read(1, 0, "dig_lo_rd");
        repeat (2 * S * D + 4) begin
            @(posedge clk); #1;
            check_display("scan");
        end
        repeat (6) bus_read(5, 0, "status");

        // Blinking on digit 1 only, plus writes to digits beyond DIGITS.
        bus_write(3, 0, 32'h0000_000F, 4'h1, "dots");
        bus_write(4, 0, 32'h0000_0002, 4'h1, "bmask");
        bus_write(1, 0, 32'h8A5B_8180, 4'hF, "dig_lo2");
        bus_write(2, 0, 32'h1234_5678, 4'hF, "dig_hi");
        bus_read(2, 0, "dig_hi_rd");
        bus_write(0, 0, 32'h0000_0003, 4'h1, "ctrl_blink");
        repeat (4 * S * D) begin
            @(posedge clk); #1;
            check_display("blink");
        end

        // Both strobes high: no acknowledge, no register change.
        @(posedge clk); #1;
        addr = BASE + 32'h4; rd = 1'b1; wr = 1'b1; mask = 4'hF; drv_val = 32'hDEAD_BEEF; drv_en = 1'b1;
        #2;
        chk("both_fc", {31'h0, (fc_bus === 1'b1)}, 32'h0);
        drv_en = 1'b0;
        #1;
        chk_released("both_bus");
        @(posedge clk); #1;
        rd = 1'b0; wr = 1'b0; mask = 4'h0; addr = 32'h0;
        bus_read(1, 0, "both_noreg");
        bus_write(0, 0, 32'h0000_0000, 4'h1, "ctrl_off");
        @(posedge clk); #1;
        chk("an_off", 32'(an), 32'h0);
        check_display("off");

        // Reset in the middle of a write.
        bus_write(0, 0, 32'h0000_0001, 4'h1, "ctrl_on");
        repeat (5) @(posedge clk);
        #1;
        addr = BASE + 32'h4; drv_val = 32'h1122_3344; drv_en = 1'b1; mask = 4'hF; wr = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        wr = 1'b0; drv_en = 1'b0; mask = 4'h0; addr = 32'h0;
        model_reset();
        #1;
        chk_released("midwr_bus");
        chk("midwr_an", 32'(an), 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        for (int off = 0; off < 6; off++) bus_read(off, 0, "post_rst_reg");

        // Byte-offset write and read.
        bus_write(1, 1, 32'h0000_00AB, 4'h1, "byte5");
        bus_read(1, 0, "byte5_word");
        bus_read(1, 2, "byte6_rd");

        // Randomized register traffic with display tracking.
        for (int i = 0; i < 60; i++) begin
            int off, lane, op;
            off = $urandom_range(0, 5);
            lane = $urandom_range(0, 3);
            op = $urandom_range(0, 3);
            case (op)
                0, 1: bus_write(off, lane, $urandom, 4'($urandom), "rnd_wr");
                2: bus_read(off, lane, "rnd_rd");
                default: begin
                    @(posedge clk); #1;
                    addr = ($urandom_range(0, 1) == 0) ? BASE - 32'h4 : BASE + 32'(4 * $urandom_range(6, 15));
                    rd = 1'b1;
                    #2;
                    chk_released("rnd_miss");
                    @(posedge clk); #1;
                    rd = 1'b0; addr = 32'h0;
                end
            endcase
            bus_read(off, 0, "rnd_back");
            @(posedge clk); #1;
            check_display("rnd_disp");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
